// File: rtl/adc_capture_pkg.sv
// -----------------------------------------------------------------------------
// adc_capture_pkg
// Shared constants for the ADC waveform capture controller:
//   - FSM state encoding
//   - bit positions inside the adc_control word written by the Nios
//   - bit positions inside the status word read back by the Nios
//   - helper that builds the status word from state + forced flag
// -----------------------------------------------------------------------------
package adc_capture_pkg;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_FILL      = 3'd1;
   localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
   localparam logic [2:0] ST_POST      = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   // adc_control bit positions; bits [7:5] are unused
   localparam int CTL_ARM     = 0;
   localparam int CTL_FORCE   = 1;
   localparam int CTL_EXT_EN  = 2;
   localparam int CTL_EXT_POL = 3;  // 0 = rising edge, 1 = falling edge
   localparam int CTL_ABORT   = 4;

   // status bit positions
   localparam int STAT_BUSY      = 0;
   localparam int STAT_WAIT_TRIG = 1;
   localparam int STAT_DONE      = 2;
   localparam int STAT_FORCED    = 3;

   function automatic logic [3:0] make_status(input logic [2:0] st,
                                              input logic       forced);
      logic [3:0] s;
      s                 = '0;
      s[STAT_BUSY]      = (st == ST_FILL) || (st == ST_WAIT_TRIG) || (st == ST_POST);
      s[STAT_WAIT_TRIG] = (st == ST_WAIT_TRIG);
      s[STAT_DONE]      = (st == ST_DONE);
      s[STAT_FORCED]    = forced;
      return s;
   endfunction

endpackage

// File: rtl/adc_wave_ram.sv
// -----------------------------------------------------------------------------
// adc_wave_ram
// Simple dual-port RAM, DEPTH x DATA_W: one write port, one read port with a
// registered output (one cycle read latency). Written so that FPGA tools map
// it onto block RAM (M10K).
// Ports:
//   clk      - clock for both ports
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address (sampled on clk)
//   rd_data  - read data, valid one cycle after rd_addr
// -----------------------------------------------------------------------------
module adc_wave_ram #(
   parameter int DEPTH  = 1024,
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array and its read register have no reset; a reset term would
   // stop the tools from mapping this onto block RAM.
   // NOTE: non-blocking assignments in clocked blocks, so every register sees
   // the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/adc_wave_capture_ctrl.sv
// -----------------------------------------------------------------------------
// adc_wave_capture_ctrl
// Streams ADC samples into a circular buffer with a pre-trigger window,
// freezes the buffer on a trigger and lets software read the waveform back
// one sample at a time, oldest pre-trigger sample first.
// Ports:
//   clk_clk        - system clock
//   reset_reset_n  - asynchronous active-low reset
//   adc_data       - ADC sample
//   adc_valid      - qualifies adc_data for one cycle
//   trig_in        - asynchronous external trigger
//   adc_control    - [0] arm [1] force_trig [2] ext_en [3] ext_pol [4] abort
//   samplenum      - readback index (0 = oldest pre-trigger sample)
//   wavesample     - readback data, 2 cycles after samplenum; 0 unless done
//   status         - [0] busy [1] wait_trig [2] done [3] trig_was_forced
// -----------------------------------------------------------------------------
module adc_wave_capture_ctrl
   import adc_capture_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int PRETRIG = 256,
   parameter int DATA_W  = 16
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   input  logic              trig_in,
   input  logic [7:0]        adc_control,
   input  logic [15:0]       samplenum,
   output logic [15:0]       wavesample,
   output logic [3:0]        status
);

   localparam int AW = $clog2(DEPTH);

   localparam int               POST_LEN = DEPTH - PRETRIG;
   localparam logic [AW:0]      PRE_TGT  = PRETRIG[AW:0];
   localparam logic [AW:0]      POST_TGT = POST_LEN[AW:0];
   localparam logic [AW-1:0]    PRE_OFS  = PRETRIG[AW-1:0];

   logic [2:0]        state;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     start_ptr;
   logic [AW-1:0]     rd_addr;
   logic [AW:0]       pre_cnt;
   logic [AW:0]       post_cnt;
   logic              trig_was_forced;
   logic              arm_q;
   logic [1:0]        trig_sync;
   logic              trig_hist;
   logic [DATA_W-1:0] rd_data;

   // Control decode
   logic arm_rise;
   logic force_trig;
   logic abort;
   logic ext_edge;
   logic trigger;
   logic capturing;
   logic wr_en;

   logic [AW-1:0] wr_ptr_inc;
   logic [AW-1:0] trig_ptr;
   logic [AW:0]   pre_nxt;
   logic [AW:0]   post_nxt;

   assign arm_rise   = adc_control[CTL_ARM] & ~arm_q;
   assign force_trig = adc_control[CTL_FORCE];
   assign abort      = adc_control[CTL_ABORT];

   // trig_sync[1] is the synchronised trigger; trig_hist is its previous value
   assign ext_edge = adc_control[CTL_EXT_EN] &
                     (adc_control[CTL_EXT_POL] ? ( trig_hist & ~trig_sync[1])
                                               : (~trig_hist &  trig_sync[1]));
   assign trigger  = force_trig | ext_edge;

   assign capturing = (state == ST_FILL) || (state == ST_WAIT_TRIG) || (state == ST_POST);
   assign wr_en     = capturing & adc_valid & ~abort;

   assign wr_ptr_inc = wr_ptr + 1'b1;
   assign pre_nxt    = pre_cnt + 1'b1;
   assign post_nxt   = post_cnt + 1'b1;

   // A sample accepted in the trigger cycle is still pre-trigger, so the
   // trigger sample is the next one to be written.
   assign trig_ptr = adc_valid ? wr_ptr_inc : wr_ptr;

   // Control bits [7:5] and samplenum bits above AW-1 carry no meaning here.
   logic unused_ok;
   assign unused_ok = &{1'b0, adc_control[7:5], samplenum};

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state           <= ST_IDLE;
         wr_ptr          <= '0;
         start_ptr       <= '0;
         rd_addr         <= '0;
         pre_cnt         <= '0;
         post_cnt        <= '0;
         trig_was_forced <= 1'b0;
         arm_q           <= 1'b0;
         trig_sync       <= '0;
         trig_hist       <= 1'b0;
      end else begin
         // Edge-detect history and the trig_in synchroniser run in every state.
         arm_q     <= adc_control[CTL_ARM];
         trig_sync <= {trig_sync[0], trig_in};
         trig_hist <= trig_sync[1];

         // Readback address: first stage of the 2-cycle readback pipeline.
         rd_addr <= start_ptr + samplenum[AW-1:0];

         if (abort) begin
            state           <= ST_IDLE;
            trig_was_forced <= 1'b0;
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  if (arm_rise) begin
                     wr_ptr          <= '0;
                     pre_cnt         <= '0;
                     trig_was_forced <= 1'b0;
                     state           <= ST_FILL;
                  end
               end

               // Triggers are not evaluated here, so they are dropped rather
               // than queued until the pre-trigger window is full.
               ST_FILL: begin
                  if (adc_valid) begin
                     wr_ptr  <= wr_ptr_inc;
                     pre_cnt <= pre_nxt;
                     if (pre_nxt == PRE_TGT) begin
                        state <= ST_WAIT_TRIG;
                     end
                  end
               end

               ST_WAIT_TRIG: begin
                  if (adc_valid) begin
                     wr_ptr <= wr_ptr_inc;
                  end
                  if (trigger) begin
                     start_ptr       <= trig_ptr - PRE_OFS;
                     post_cnt        <= '0;
                     trig_was_forced <= force_trig & ~ext_edge;
                     state           <= ST_POST;
                  end
               end

               ST_POST: begin
                  if (adc_valid) begin
                     wr_ptr   <= wr_ptr_inc;
                     post_cnt <= post_nxt;
                     if (post_nxt == POST_TGT) begin
                        state <= ST_DONE;
                     end
                  end
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   adc_wave_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk_clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (adc_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Gated on state so readback is 0 immediately on reset or abort, even
   // though the RAM output register itself is never cleared.
   assign wavesample = (state == ST_DONE) ? 16'(rd_data) : 16'h0000;
   assign status     = make_status(state, trig_was_forced);

endmodule

// File: tb/tb_adc_wave_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_wave_capture_ctrl
// Directed bench for adc_wave_capture_ctrl with DEPTH = 16, PRETRIG = 4.
// The stimulus process drives ramp data and control, and queues the value it
// expects on status or wavesample together with the cycle it becomes visible.
// The monitor process pops and compares once that cycle has been reached.
// -----------------------------------------------------------------------------
module tb_adc_wave_capture_ctrl;

   localparam int DEPTH   = 16;
   localparam int PRETRIG = 4;
   localparam int DATA_W  = 16;

   localparam logic [7:0] C_ARM = 8'h01;
   localparam logic [7:0] C_FRC = 8'h02;
   localparam logic [7:0] C_EXT = 8'h04;
   localparam logic [7:0] C_POL = 8'h08;
   localparam logic [7:0] C_ABT = 8'h10;

   logic              clk_clk;
   logic              reset_reset_n;
   logic [DATA_W-1:0] adc_data;
   logic              adc_valid;
   logic              trig_in;
   logic [7:0]        adc_control;
   logic [15:0]       samplenum;
   logic [15:0]       wavesample;
   logic [3:0]        status;

   adc_wave_capture_ctrl #(
      .DEPTH   (DEPTH),
      .PRETRIG (PRETRIG),
      .DATA_W  (DATA_W)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .adc_data      (adc_data),
      .adc_valid     (adc_valid),
      .trig_in       (trig_in),
      .adc_control   (adc_control),
      .samplenum     (samplenum),
      .wavesample    (wavesample),
      .status        (status)
   );

   initial begin
      clk_clk = 1'b0;
      forever #5 clk_clk = ~clk_clk;
   end

   int cyc;
   always @(posedge clk_clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_wave;
      int          due;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_checks;
   int   n_fail;
   logic [15:0] ramp;

   // ---------------------------------------------------------------- monitor
   initial begin
      exp_t        it;
      logic [15:0] act;
      forever begin
         @(posedge clk_clk);
         #1;
         while (q.size() != 0 && q[0].due <= cyc) begin
            it  = q.pop_front();
            act = it.is_wave ? wavesample : {12'h000, status};
            n_checks++;
            if (act !== it.exp) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h", it.name, act, it.exp);
            end
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic push(input bit w, input string nm, input logic [15:0] e, input int dly);
      exp_t it;
      it.is_wave = w;
      it.due     = cyc + dly;
      it.exp     = e;
      it.name    = nm;
      q.push_back(it);
   endtask

   // status expected after the coming clock edge
   task automatic exp_status(input string nm, input logic [3:0] e);
      push(1'b0, nm, {12'h000, e}, 1);
   endtask

   // one clock cycle of ADC stimulus; valid samples carry the ramp value
   task automatic drive(input bit v);
      @(negedge clk_clk);
      adc_valid = v;
      adc_data  = v ? ramp : '0;
      if (v) ramp++;
   endtask

   task automatic arm_with(input logic [7:0] mode);
      drive(1'b0);
      adc_control = mode;
      drive(1'b0);
      adc_control = mode | C_ARM;
   endtask

   // readback with valid samples still streaming (they must be ignored)
   task automatic read_check(input logic [15:0] idx, input logic [15:0] e);
      drive(1'b1);
      samplenum = idx;
      push(1'b1, $sformatf("read samplenum %h", idx), e, 2);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      adc_data      = '0;
      adc_valid     = 1'b0;
      trig_in       = 1'b0;
      adc_control   = 8'h00;
      samplenum     = 16'h0000;
      ramp          = 16'd0;
      reset_reset_n = 1'b1;
      #1 reset_reset_n = 1'b0;

      // Reset state
      drive(1'b0);
      exp_status("reset status", 4'b0000);
      push(1'b1, "reset wavesample", 16'h0000, 1);
      drive(1'b0);
      drive(1'b0);
      reset_reset_n = 1'b1;

      // Samples without arm are ignored
      ramp = 16'd10;
      for (int k = 0; k < 5; k++) drive(1'b1);
      exp_status("idle ignores samples", 4'b0000);
      read_check(16'h0000, 16'h0000);

      // Forced trigger: trigger sample 100, window 96..111
      arm_with(8'h00);
      ramp = 16'd90;
      for (int v = 90; v <= 111; v++) begin
         drive(1'b1);
         if (v == 93)  exp_status("forced: wait_trig", 4'b0011);
         if (v == 99)  begin adc_control = C_ARM | C_FRC; exp_status("forced: post", 4'b1001); end
         if (v == 100) begin adc_control = C_ARM; samplenum = 16'h0000;
                             push(1'b1, "wavesample 0 during post", 16'h0000, 2); end
         if (v == 110) exp_status("forced: still post", 4'b1001);
         if (v == 111) exp_status("forced: done", 4'b1100);
      end
      for (int i = 0; i < 16; i++) read_check(16'(i), 16'(96 + i));

      // External rising edge: first edge in FILL ignored, second one captures
      arm_with(C_EXT);
      ramp = 16'd200;
      for (int v = 200; v <= 222; v++) begin
         drive(1'b1);
         if (v == 200) trig_in = 1'b1;
         if (v == 203) exp_status("ext rise: wait_trig", 4'b0011);
         if (v == 205) trig_in = 1'b0;
         if (v == 208) trig_in = 1'b1;
         if (v == 209) exp_status("ext rise: fill edge ignored", 4'b0011);
         if (v == 210) exp_status("ext rise: post", 4'b0001);
         if (v == 222) exp_status("ext rise: done", 4'b0100);
      end
      read_check(16'd0,  16'd207);
      read_check(16'd4,  16'd211);
      read_check(16'd9,  16'd216);
      read_check(16'd15, 16'd222);

      // External falling edge: rising edge in WAIT_TRIG must not trigger
      arm_with(C_EXT | C_POL);
      ramp = 16'd300;
      for (int v = 300; v <= 321; v++) begin
         drive(1'b1);
         if (v == 300) trig_in = 1'b0;
         if (v == 304) trig_in = 1'b1;
         if (v == 307) begin exp_status("ext fall: rise ignored", 4'b0011); trig_in = 1'b0; end
         if (v == 309) exp_status("ext fall: post", 4'b0001);
         if (v == 321) exp_status("ext fall: done", 4'b0100);
      end
      read_check(16'd0,  16'd306);
      read_check(16'd4,  16'd310);
      read_check(16'd10, 16'd316);

      // Abort during POST
      arm_with(8'h00);
      ramp = 16'd400;
      for (int v = 400; v <= 408; v++) begin
         drive(1'b1);
         if (v == 405) adc_control = C_ARM | C_FRC;
         if (v == 406) adc_control = C_ARM;
         if (v == 408) begin
            adc_control = C_ARM | C_ABT;
            samplenum   = 16'h0000;
            exp_status("abort: status cleared", 4'b0000);
            push(1'b1, "abort: wavesample", 16'h0000, 2);
         end
      end
      drive(1'b1);
      adc_control = 8'h00;

      // New capture after abort; force pulse in FILL is ignored
      arm_with(8'h00);
      ramp = 16'd500;
      for (int v = 500; v <= 519; v++) begin
         drive(1'b1);
         if (v == 501) adc_control = C_ARM | C_FRC;
         if (v == 502) adc_control = C_ARM;
         if (v == 505) exp_status("after abort: fill force ignored", 4'b0011);
         if (v == 507) begin adc_control = C_ARM | C_FRC; exp_status("after abort: post", 4'b1001); end
         if (v == 508) adc_control = C_ARM;
         if (v == 519) exp_status("after abort: done", 4'b1100);
      end
      read_check(16'd0,  16'd504);
      read_check(16'd4,  16'd508);
      read_check(16'd11, 16'd515);
      read_check(16'd15, 16'd519);

      // Gapped adc_valid: one valid sample every third cycle
      arm_with(8'h00);
      ramp = 16'd600;
      for (int v = 600; v <= 621; v++) begin
         drive(1'b0);
         drive(1'b0);
         if (v == 610) adc_control = C_ARM;
         drive(1'b1);
         if (v == 603) exp_status("gapped: wait_trig", 4'b0011);
         if (v == 609) begin adc_control = C_ARM | C_FRC; exp_status("gapped: post", 4'b1001); end
         if (v == 620) exp_status("gapped: still post", 4'b1001);
         if (v == 621) exp_status("gapped: done", 4'b1100);
      end
      for (int i = 0; i < 16; i++) read_check(16'(i), 16'(606 + i));

      // Arm held high after DONE: no restart, buffer stays frozen
      ramp = 16'd650;
      for (int k = 0; k < 5; k++) drive(1'b1);
      exp_status("arm held: still done", 4'b1100);
      read_check(16'd0, 16'd606);

      // Arm toggled: new capture; index wrap on samplenum
      arm_with(8'h00);
      ramp = 16'd700;
      for (int v = 700; v <= 716; v++) begin
         drive(1'b1);
         if (v == 704) adc_control = C_ARM | C_FRC;
         if (v == 705) adc_control = C_ARM;
         if (v == 716) exp_status("rearm: done", 4'b1100);
      end
      read_check(16'h0003, 16'd704);
      read_check(16'h0013, 16'd704);
      read_check(16'hFFF0, 16'd701);

      // Reset in the middle of POST
      arm_with(8'h00);
      ramp = 16'd800;
      for (int v = 800; v <= 808; v++) begin
         drive(1'b1);
         if (v == 805) adc_control = C_ARM | C_FRC;
         if (v == 806) adc_control = C_ARM;
      end
      #2;
      reset_reset_n = 1'b0;
      adc_control   = 8'h00;
      samplenum     = 16'h0000;
      exp_status("mid-post reset: status", 4'b0000);
      push(1'b1, "mid-post reset: wavesample", 16'h0000, 1);
      drive(1'b1);
      drive(1'b1);
      reset_reset_n = 1'b1;
      ramp = 16'd850;
      for (int k = 0; k < 4; k++) drive(1'b1);
      exp_status("after reset: idle", 4'b0000);

      // Capture after reset
      arm_with(8'h00);
      ramp = 16'd900;
      for (int v = 900; v <= 916; v++) begin
         drive(1'b1);
         if (v == 904) adc_control = C_ARM | C_FRC;
         if (v == 905) adc_control = C_ARM;
         if (v == 916) exp_status("after reset: done", 4'b1100);
      end
      read_check(16'd0,  16'd901);
      read_check(16'd15, 16'd916);

      // Drain the scoreboard within a bounded number of cycles
      for (int k = 0; k < 20 && q.size() != 0; k++) drive(1'b0);
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expected outputs never observed, required 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
